// File: rtl/pswd_writer_pkg.sv
// Shared definitions for the password writer and the password checker.
//   - pswd_state_t : writer FSM states
//   - PSWD_DIGITS / DIG_W / PSWD_W : password geometry (six 4-bit digits)
//   - PSWD_ADDR_W / ID_W : password RAM address and player ID widths
//   - pswd_addr()  : player ID -> password RAM address
package pswd_writer_pkg;

  localparam int PSWD_DIGITS = 6;
  localparam int DIG_W       = 4;
  localparam int PSWD_W      = 24;
  localparam int PSWD_ADDR_W = 5;
  localparam int ID_W        = 3;
  localparam int DIG_CNT_W   = 3;

  typedef enum logic [3:0] {
    IDLE,
    NEW_DIG,
    CONF_DIG,
    COMPARE,
    WRITE,
    WAIT,
    DONE,
    FAIL,
    LOCKED
  } pswd_state_t;

  // Each player owns one RAM word; the upper address bits are reserved.
  function automatic logic [PSWD_ADDR_W-1:0] pswd_addr(input logic [ID_W-1:0] id);
    return {{(PSWD_ADDR_W-ID_W){1'b0}}, id};
  endfunction

endpackage

// File: rtl/pswd_writer_digit_collector.sv
// pswd_digit_collector: captures six keypad digits into a 24-bit value,
// first digit ending up in the top nibble.
//   clk, rst : clock, synchronous active-high reset
//   start    : level; holds the collector empty (counter and value cleared)
//   digit    : 4-bit keypad digit
//   strobe   : one-cycle digit strobe
//   value    : collected value, including the digit being strobed this cycle
//   full     : one-cycle pulse on the strobe that delivers the sixth digit
// The collector empties itself after a full pulse so the next entry starts
// from a clean counter without an explicit start.
module pswd_digit_collector
  import pswd_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIG_W-1:0]  digit,
  input  logic              strobe,
  output logic [PSWD_W-1:0] value,
  output logic              full
);

  localparam logic [DIG_CNT_W-1:0] LAST_DIG = DIG_CNT_W'(PSWD_DIGITS - 1);

  logic [PSWD_W-1:0]    shreg;
  logic [DIG_CNT_W-1:0] cnt;

  // Presenting the shifted value combinationally lets the owner capture the
  // complete password on the same edge as the sixth strobe.
  assign value = strobe ? {shreg[PSWD_W-DIG_W-1:0], digit} : shreg;
  assign full  = strobe && !start && (cnt == LAST_DIG);

  always_ff @(posedge clk) begin
    if (rst || start || full) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (strobe) begin
      shreg <= value;
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pswd_writer.sv
// pswd_writer: lets a logged-in (non-guest) player change their password.
// Six new digits are collected (optionally followed by six confirm digits
// that must match), then the password is written to the player's RAM word.
//
// Build option: define PSWD_CONFIRM_EN to enable the confirm entry, the
// compare step, mismatch counting and lockout. Without it, the write follows
// the sixth new digit directly and Change_fail / Change_locked read 0.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   PlayerPswd         : current keypad digit
//   Pswd_enter         : one-cycle digit strobe
//   Change_req         : one-cycle change request
//   Loggedin, isGuest  : session level and guest flag
//   Internal_PlayerID  : logged-in player's ID (latched at request)
//   PswdRAM_addr/wdata/we : password RAM write port
//   Change_busy        : high whenever not IDLE
//   Change_done/fail   : one-cycle result pulses
//   Change_locked      : lockout level
module pswd_writer
  import pswd_writer_pkg::*;
#(
  parameter int RAM_WAIT     = 2,
  parameter int MAX_MISMATCH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIG_W-1:0]       PlayerPswd,
  input  logic                   Pswd_enter,
  input  logic                   Change_req,
  input  logic                   Loggedin,
  input  logic                   isGuest,
  input  logic [ID_W-1:0]        Internal_PlayerID,
  output logic [PSWD_ADDR_W-1:0] PswdRAM_addr,
  output logic [PSWD_W-1:0]      PswdRAM_wdata,
  output logic                   PswdRAM_we,
  output logic                   Change_busy,
  output logic                   Change_done,
  output logic                   Change_fail,
  output logic                   Change_locked
);

  localparam logic [2:0] WAIT_LAST = 3'(RAM_WAIT - 1);

  pswd_state_t       state;
  logic [ID_W-1:0]   id_q;
  logic [PSWD_W-1:0] new_reg;
  logic [2:0]        wait_cnt;

  logic              in_entry;
  logic              col_start;
  logic              col_strobe;
  logic              col_full;
  logic [PSWD_W-1:0] col_value;

`ifdef PSWD_CONFIRM_EN
  localparam logic [1:0] MM_LIMIT = 2'(MAX_MISMATCH);
  logic [PSWD_W-1:0] conf_reg;
  logic [1:0]        mm_cnt;
  logic [1:0]        mm_inc;
  assign mm_inc = (mm_cnt == 2'd3) ? 2'd3 : mm_cnt + 2'd1;
`else
  assign Change_fail   = 1'b0;
  assign Change_locked = 1'b0;
`endif

  // The collector is held empty outside the digit states, so an abort or a
  // fresh request always starts from digit one. Gating the strobe with
  // Loggedin drops a digit that coincides with an abort.
  assign in_entry   = (state == NEW_DIG) || (state == CONF_DIG);
  assign col_start  = !in_entry;
  assign col_strobe = in_entry && Pswd_enter && Loggedin;

  pswd_digit_collector u_col (
    .clk    (clk),
    .rst    (rst),
    .start  (col_start),
    .digit  (PlayerPswd),
    .strobe (col_strobe),
    .value  (col_value),
    .full   (col_full)
  );

  // new_reg only changes in NEW_DIG, so the write data is stable from
  // WRITE through DONE.
  assign PswdRAM_addr  = pswd_addr(id_q);
  assign PswdRAM_wdata = new_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      id_q        <= '0;
      new_reg     <= '0;
      wait_cnt    <= '0;
      PswdRAM_we  <= 1'b0;
      Change_busy <= 1'b0;
      Change_done <= 1'b0;
`ifdef PSWD_CONFIRM_EN
      conf_reg      <= '0;
      mm_cnt        <= '0;
      Change_fail   <= 1'b0;
      Change_locked <= 1'b0;
`endif
    end else begin
      PswdRAM_we  <= 1'b0;
      Change_done <= 1'b0;
`ifdef PSWD_CONFIRM_EN
      Change_fail <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (Change_req && Loggedin && !isGuest && !Change_locked) begin
            state       <= NEW_DIG;
            Change_busy <= 1'b1;
            id_q        <= Internal_PlayerID;
          end
        end

        NEW_DIG: begin
          if (!Loggedin) begin
            state       <= IDLE;
            Change_busy <= 1'b0;
          end else if (col_full) begin
            new_reg <= col_value;
`ifdef PSWD_CONFIRM_EN
            state   <= CONF_DIG;
`else
            state      <= WRITE;
            PswdRAM_we <= 1'b1;
`endif
          end
        end

`ifdef PSWD_CONFIRM_EN
        CONF_DIG: begin
          if (!Loggedin) begin
            state       <= IDLE;
            Change_busy <= 1'b0;
          end else if (col_full) begin
            conf_reg <= col_value;
            state    <= COMPARE;
          end
        end

        COMPARE: begin
          if (!Loggedin) begin
            state       <= IDLE;
            Change_busy <= 1'b0;
          end else if (new_reg == conf_reg) begin
            state      <= WRITE;
            PswdRAM_we <= 1'b1;
          end else begin
            state       <= FAIL;
            Change_fail <= 1'b1;
          end
        end

        FAIL: begin
          mm_cnt <= mm_inc;
          if (mm_inc == MM_LIMIT) begin
            state         <= LOCKED;
            Change_locked <= 1'b1;
          end else begin
            state       <= IDLE;
            Change_busy <= 1'b0;
          end
        end

        LOCKED: begin
          if (!Loggedin) begin
            state         <= IDLE;
            mm_cnt        <= '0;
            Change_locked <= 1'b0;
            Change_busy   <= 1'b0;
          end
        end
`endif

        // From here on the write completes even if the session ends.
        WRITE: begin
          state    <= WAIT;
          wait_cnt <= '0;
`ifdef PSWD_CONFIRM_EN
          mm_cnt   <= '0;
`endif
        end

        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state       <= DONE;
            Change_done <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end

        DONE: begin
          state       <= IDLE;
          Change_busy <= 1'b0;
        end

        default: begin
          state       <= IDLE;
          Change_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pswd_writer.sv
// Self-checking bench for pswd_writer. Works in both builds; the confirm,
// mismatch and lockout scenarios are compiled in with PSWD_CONFIRM_EN.
module tb_pswd_writer;

  localparam int RW = 3;
  localparam int MM = 3;
`ifdef PSWD_CONFIRM_EN
  localparam bit CONFIRM = 1'b1;
`else
  localparam bit CONFIRM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  PlayerPswd;
  logic        Pswd_enter, Change_req, Loggedin, isGuest;
  logic [2:0]  Internal_PlayerID;
  logic [4:0]  PswdRAM_addr;
  logic [23:0] PswdRAM_wdata;
  logic        PswdRAM_we, Change_busy, Change_done, Change_fail, Change_locked;

  pswd_writer #(.RAM_WAIT(RW), .MAX_MISMATCH(MM)) dut (
    .clk               (clk),
    .rst               (rst),
    .PlayerPswd        (PlayerPswd),
    .Pswd_enter        (Pswd_enter),
    .Change_req        (Change_req),
    .Loggedin          (Loggedin),
    .isGuest           (isGuest),
    .Internal_PlayerID (Internal_PlayerID),
    .PswdRAM_addr      (PswdRAM_addr),
    .PswdRAM_wdata     (PswdRAM_wdata),
    .PswdRAM_we        (PswdRAM_we),
    .Change_busy       (Change_busy),
    .Change_done       (Change_done),
    .Change_fail       (Change_fail),
    .Change_locked     (Change_locked)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mm       = 0;  // model: consecutive mismatches since last write/unlock

  // Observed RAM traffic and pulses, sampled mid-cycle.
  int          we_cnt = 0, done_cnt = 0, fail_cnt = 0, we_cyc = 0, done_cyc = 0;
  logic [23:0] we_wdata = '0, done_wdata = '0;
  logic [4:0]  we_addr = '0;
  bit          lock_seen = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (PswdRAM_we) begin
      we_cnt++; we_cyc = cyc; we_wdata = PswdRAM_wdata; we_addr = PswdRAM_addr;
    end
    if (Change_done) begin
      done_cnt++; done_cyc = cyc; done_wdata = PswdRAM_wdata;
    end
    if (Change_fail) fail_cnt++;
    if (Change_locked) lock_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed time limit, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Enter the first n digits of a six-digit code, most significant first,
  // with random idle gaps between strobes.
  task automatic enter_digits(input logic [23:0] code, input int n);
    int unsigned c;
    c = code;
    for (int i = 0; i < n; i++) begin
      tick($urandom_range(0, 2));
      PlayerPswd = 4'((c / (32'd1 << (4 * (5 - i)))) % 16);
      Pswd_enter = 1'b1;
      tick(1);
      Pswd_enter = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (Change_busy && !Change_locked && n < 60) begin tick(1); n++; end
    chk("settle_timeout", 32'(n < 60), 1);
    tick(2);
  endtask

  task automatic request(input logic [2:0] id);
    Internal_PlayerID = id; Loggedin = 1'b1; isGuest = 1'b0;
    Change_req = 1'b1; tick(1); Change_req = 1'b0;
    Internal_PlayerID = ~id;  // later changes must not move the address
    chk("busy_after_req", Change_busy, 1);
    chk("addr_latched", PswdRAM_addr, {2'b00, id});
  endtask

  task automatic session(input logic [2:0] id, input logic [23:0] nc,
                         input logic [23:0] cc, input bit drop_w);
    request(id);
    enter_digits(nc, 6);
    if (CONFIRM) begin
      enter_digits(cc, 6);
      tick(1);
    end
    if (drop_w) Loggedin = 1'b0;  // now in WRITE: must still complete
    wait_idle();
    Loggedin = 1'b1;
  endtask

  task automatic good_session(input logic [2:0] id, input logic [23:0] nc, input bit drop_w);
    int w0, d0, f0;
    w0 = we_cnt; d0 = done_cnt; f0 = fail_cnt;
    session(id, nc, nc, drop_w);
    chk("we_count", we_cnt - w0, 1);
    chk("we_wdata", we_wdata, nc);
    chk("we_addr", we_addr, {2'b00, id});
    chk("done_count", done_cnt - d0, 1);
    chk("done_latency", done_cyc - we_cyc, RW + 1);
    chk("done_wdata", done_wdata, nc);
    chk("no_fail", fail_cnt - f0, 0);
    chk("idle_busy", Change_busy, 0);
  endtask

`ifdef PSWD_CONFIRM_EN
  task automatic mm_session(input logic [23:0] nc, input logic [23:0] cc);
    int w0, d0, f0;
    bit match;
    w0 = we_cnt; d0 = done_cnt; f0 = fail_cnt;
    match = (nc == cc);
    session(3'($urandom), nc, cc, 1'b0);
    if (match) mm = 0; else if (mm < 3) mm++;
    chk("mm_we", we_cnt - w0, 32'(match));
    chk("mm_done", done_cnt - d0, 32'(match));
    chk("mm_fail", fail_cnt - f0, 32'(!match));
    chk("mm_locked", Change_locked, 32'(mm >= MM));
  endtask
`endif

  initial begin
    logic [23:0] nc;
    logic [2:0]  id;
    int          w0, d0, f0;

    rst = 1'b1; PlayerPswd = '0; Pswd_enter = 1'b0; Change_req = 1'b0;
    Loggedin = 1'b0; isGuest = 1'b0; Internal_PlayerID = '0;
    tick(3);
    chk("rst_addr", PswdRAM_addr, 0);
    chk("rst_wdata", PswdRAM_wdata, 0);
    chk("rst_we", PswdRAM_we, 0);
    chk("rst_busy", Change_busy, 0);
    chk("rst_done", Change_done, 0);
    chk("rst_fail", Change_fail, 0);
    chk("rst_locked", Change_locked, 0);
    rst = 1'b0;
    tick(1);

    // Requests from a guest or a logged-out player are ignored.
    Loggedin = 1'b1; isGuest = 1'b1; Internal_PlayerID = 3'd6;
    Change_req = 1'b1; tick(1); Change_req = 1'b0;
    chk("guest_busy", Change_busy, 0);
    tick(1);
    chk("guest_busy_late", Change_busy, 0);
    Loggedin = 1'b0; isGuest = 1'b0;
    Change_req = 1'b1; tick(1); Change_req = 1'b0;
    chk("logout_busy", Change_busy, 0);
    chk("logout_addr", PswdRAM_addr, 0);

    // Stray digits while idle must not leak into the next password.
    Loggedin = 1'b1;
    enter_digits(24'hABCDEF, 3);
    chk("stray_busy", Change_busy, 0);

    // Directed first pass, then random players and codes.
    for (int it = 0; it < 6; it++) begin
      id = (it == 0) ? 3'd3 : 3'($urandom);
      nc = (it == 0) ? (CONFIRM ? 24'h123456 : 24'h987654) : 24'($urandom);
      good_session(id, nc, it == 2);
    end

    // Abort mid-entry with a coincident digit strobe.
    w0 = we_cnt; d0 = done_cnt; f0 = fail_cnt;
    nc = 24'($urandom);
    request(3'd5);
    if (CONFIRM) begin
      enter_digits(nc, 6);
      enter_digits(nc, 4);
    end else begin
      enter_digits(nc, 4);
    end
    Loggedin = 1'b0; PlayerPswd = 4'h7; Pswd_enter = 1'b1;
    tick(1);
    Pswd_enter = 1'b0;
    chk("abort_busy", Change_busy, 0);
    Loggedin = 1'b1;
    tick(3);
    chk("abort_we", we_cnt - w0, 0);
    chk("abort_done", done_cnt - d0, 0);
    chk("abort_fail", fail_cnt - f0, 0);
    good_session(3'd1, 24'($urandom), 1'b0);

    // Reset while waiting on the RAM: no completion.
    w0 = we_cnt; d0 = done_cnt;
    nc = 24'($urandom);
    request(3'd7);
    enter_digits(nc, 6);
    if (CONFIRM) begin
      enter_digits(nc, 6);
      tick(1);
    end
    chk("pre_wait_we", PswdRAM_we, 1);
    tick(1);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("wrst_addr", PswdRAM_addr, 0);
    chk("wrst_wdata", PswdRAM_wdata, 0);
    chk("wrst_we", PswdRAM_we, 0);
    chk("wrst_busy", Change_busy, 0);
    chk("wrst_done", Change_done, 0);
    chk("wrst_locked", Change_locked, 0);
    tick(RW + 3);
    chk("wrst_no_done", done_cnt - d0, 0);
    chk("wrst_one_we", we_cnt - w0, 1);
    mm = 0;

`ifdef PSWD_CONFIRM_EN
    // Mismatches below the limit, then a good write clears the count.
    mm_session(24'h123456, 24'h123457);
    for (int k = 1; k < MM - 1; k++) begin
      nc = 24'($urandom);
      mm_session(nc, nc ^ 24'($urandom_range(1, 24'hFFFFFF)));
    end
    nc = 24'($urandom);
    mm_session(nc, nc);
    for (int k = 0; k < MM; k++) begin
      nc = 24'($urandom);
      mm_session(nc, nc ^ 24'($urandom_range(1, 24'hFFFFFF)));
    end
    chk("lock_seen", 32'(lock_seen), 1);

    // Locked: requests and digits go nowhere until logout.
    w0 = we_cnt;
    Change_req = 1'b1; tick(1); Change_req = 1'b0;
    enter_digits(24'($urandom), 6);
    tick(3);
    chk("locked_hold", Change_locked, 1);
    chk("locked_busy", Change_busy, 1);
    chk("locked_no_we", we_cnt - w0, 0);
    Loggedin = 1'b0;
    tick(1);
    chk("unlock_locked", Change_locked, 0);
    chk("unlock_busy", Change_busy, 0);
    mm = 0;
    Loggedin = 1'b1;
    tick(1);
    nc = 24'($urandom);
    mm_session(nc, ~nc);
`else
    chk("fail_never", fail_cnt, 0);
    chk("lock_never", 32'(lock_seen), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pswd_writer.md
PSWD_WRITER -- requirements
Module: pswd_writer

Interface
REQ-001 SHALL have parameter RAM_WAIT, default 2, meaning the number of idle cycles after the write strobe before completion (1..7).
REQ-002 SHALL have parameter MAX_MISMATCH, default 3, meaning the number of consecutive confirm mismatches that force a lockout (1..3).
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port PlayerPswd  input  4  current keypad digit.
REQ-005 SHALL have port Pswd_enter  input  1  one-cycle digit strobe.
REQ-006 SHALL have port Change_req  input  1  one-cycle request to change the password.
REQ-007 SHALL have port Loggedin  input  1  session-active level.
REQ-008 SHALL have port isGuest  input  1  guest session flag.
REQ-009 SHALL have port Internal_PlayerID  input  3  ID of the logged-in player.
REQ-010 SHALL have port PswdRAM_addr  output  5  write address.
REQ-011 SHALL have port PswdRAM_wdata  output  24  new password, six 4-bit digits, first digit in [23:20].
REQ-012 SHALL have port PswdRAM_we  output  1  one-cycle write strobe.
REQ-013 SHALL have port Change_busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port Change_done  output  1  one-cycle success pulse.
REQ-015 SHALL have port Change_fail  output  1  one-cycle failure pulse.
REQ-016 SHALL have port Change_locked  output  1  lockout level.

Function
REQ-017 SHALL use states IDLE, NEW_DIG, CONF_DIG, COMPARE, WRITE, WAIT, DONE, FAIL and LOCKED.
REQ-018 IDLE SHALL go to NEW_DIG on Change_req=1 with Loggedin=1, isGuest=0 and Change_locked=0; otherwise the request is ignored with no pulse.
REQ-019 On leaving IDLE, the block SHALL latch Internal_PlayerID, and PswdRAM_addr SHALL be {2'b00, latched ID} until the next IDLE exit.
REQ-020 NEW_DIG SHALL shift PlayerPswd into new_reg on each Pswd_enter, first digit landing in [23:20], under a 3-bit digit counter.
REQ-021 After the sixth digit, NEW_DIG SHALL go to CONF_DIG with the counter cleared.
REQ-022 CONF_DIG SHALL capture six digits into conf_reg in the same way, then go to COMPARE.
REQ-023 COMPARE (one cycle) SHALL go to WRITE if new_reg == conf_reg, else to FAIL.
REQ-024 WRITE SHALL assert PswdRAM_we for exactly one cycle with PswdRAM_wdata = new_reg, clear the mismatch counter, then go to WAIT.
REQ-025 WAIT SHALL hold for RAM_WAIT cycles, then go to DONE.
REQ-026 DONE SHALL pulse Change_done for one cycle, then go to IDLE.
REQ-027 FAIL SHALL pulse Change_fail for one cycle and increment a saturating 2-bit mismatch counter.
REQ-028 FAIL SHALL go to LOCKED if the incremented count equals MAX_MISMATCH, else to IDLE.
REQ-029 LOCKED SHALL hold Change_locked=1 and stay there until Loggedin falls, then clear the counter and go to IDLE.
REQ-030 Loggedin falling in NEW_DIG, CONF_DIG or COMPARE SHALL abort to IDLE next cycle with no write and no pulse.
REQ-031 Once WRITE is reached, the write SHALL complete regardless of Loggedin.
REQ-032 Pswd_enter outside NEW_DIG/CONF_DIG and Change_req outside IDLE SHALL be ignored.
REQ-033 A Pswd_enter coincident with an abort SHALL be dropped.
REQ-034 PswdRAM_wdata SHALL be held stable from WRITE through DONE.

Reset
REQ-035 With rst=1 at a clock edge, the block SHALL enter IDLE with all outputs 0, new_reg, conf_reg and both counters 0, regardless of current state.
REQ-036 A reset during WAIT SHALL produce no Change_done.

Configuration
REQ-037 With PSWD_CONFIRM_EN defined, the CONF_DIG/COMPARE path SHALL be as specified in REQ-022 and REQ-023.
REQ-038 Without PSWD_CONFIRM_EN, NEW_DIG SHALL go directly to WRITE after the sixth digit, and FAIL/LOCKED SHALL be unreachable, with Change_fail and Change_locked tied to 0.

Structure
REQ-039 The shared package SHALL hold the state enum, PSWD_DIGITS=6, PSWD_W=24 and the address width 5, shared with the password checker.
REQ-040 The 6-digit shift-capture SHALL be one sub-module, pswd_digit_collector (start, digit, strobe -> 24-bit value, full pulse), instantiated once and reused for both entries.

Verification
REQ-041 Logged-in player 3 requests a change and enters 1,2,3,4,5,6 twice -> one PswdRAM_we at addr 5'd3 with wdata 24'h123456, then Change_done exactly RAM_WAIT+1 cycles after the strobe.
REQ-042 Player enters new 123456 and confirms 123457 -> Change_fail pulse, no we; after three such mismatches -> Change_locked=1, further Change_req ignored until Loggedin drops.
REQ-043 Change_req with isGuest=1, or with Loggedin=0 -> no state change, Change_busy stays 0.
REQ-044 Loggedin dropped after the 4th confirm digit -> IDLE next cycle, no we, no pulses.
REQ-045 rst=1 during WAIT -> all outputs 0 next cycle, Change_done never asserted.
REQ-046 Built without PSWD_CONFIRM_EN, six digits 9,8,7,6,5,4 -> write of 24'h987654 with no confirm phase.
